keypad_digit_capture: RTL and testbench

KEYPAD_DIGIT_CAPTURE -- requirements
Module: keypad_digit_capture

---
 rtl/keypad_digit_capture_pkg.sv | 32 +++
 rtl/sevenseg_decoder.sv | 14 +
 rtl/keypad_digit_capture.sv | 108 ++++++++++
 tb/tb_keypad_digit_capture.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_digit_capture_pkg.sv
// Shared types and tables for the keypad digit capture block.
package keypad_digit_capture_pkg;

  // Key debounce FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_e;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

endpackage

// File: rtl/sevenseg_decoder.sv
// Hex nibble to active-low seven-segment pattern.
module sevenseg_decoder
  import keypad_digit_capture_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure table lookup; no state
  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/keypad_digit_capture.sv
// Debounces keypad scanner events, keeps the last two accepted keys and
// multiplexes them onto a two-digit seven-segment display.
module keypad_digit_capture
  import keypad_digit_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MUX_BITS        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hex,
  input  logic       hexen,
  input  logic       colen,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  kp_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           candidate;
  // First PRESS_DB cycle is a grace cycle: the scanner may still be driving
  // its columns on the cycle it reports the key, so colen is not judged yet.
  logic                 armed;
  logic [MUX_BITS-1:0]  refresh;
  logic                 sel;
  logic [3:0]           shown;

  // Debounce FSM with registered digit shift and one-cycle accept pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      candidate <= '0;
      armed     <= 1'b0;
      digit_new <= '0;
      digit_old <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hexen) begin
            candidate <= hex;
            cnt       <= '0;
            armed     <= 1'b0;
            state     <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!armed) begin
            armed <= 1'b1;
          end else if (colen) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            digit_old <= digit_new;
            digit_new <= candidate;
            key_valid <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (colen) begin
            cnt   <= '0;
            state <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!colen) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running display refresh counter; MSB picks the digit
  always_ff @(posedge clk) begin
    if (!reset) refresh <= '0;
    else        refresh <= refresh + 1'b1;
  end

  // Digit select and active-low anode drive
  always_comb begin
    sel   = refresh[MUX_BITS-1];
    an    = sel ? 2'b01 : 2'b10;
    shown = sel ? digit_old : digit_new;
  end

  sevenseg_decoder u_dec (
    .hex (shown),
    .seg (seg)
  );

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Randomized + directed bench for keypad_digit_capture with a behavioural model.
module tb_keypad_digit_capture;

  localparam int D  = 4;
  localparam int MB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hex;
  logic       hexen;
  logic       colen;
  logic [3:0] digit_new, digit_old;
  logic       key_valid;
  logic [6:0] seg;
  logic [1:0] an;

  keypad_digit_capture #(.DEBOUNCE_CYCLES(D), .MUX_BITS(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .hex       (hex),
    .hexen     (hexen),
    .colen     (colen),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .key_valid (key_valid),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int kv_cnt = 0;
  bit chk_on = 1'b0;

  // Behavioural model: mode 0 waiting, 1 pressing, 2 key down
  int       m_mode, m_since, m_hi, m_ref;
  int       m_new, m_old, m_cand;
  bit       m_kv;
  logic [6:0] segtab [16];

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic model_edge();
    if (!reset) begin
      m_mode = 0; m_new = 0; m_old = 0; m_kv = 0; m_ref = 0; m_cand = 0;
    end else begin
      m_kv  = 0;
      m_ref = (m_ref + 1) % (1 << MB);
      case (m_mode)
        0: if (hexen) begin m_cand = int'(hex); m_mode = 1; m_since = 0; end
        1: begin
          m_since++;
          // any high colen after the grace edge aborts; D low samples accept
          if (m_since >= 2 && colen) m_mode = 0;
          else if (m_since == D + 1) begin
            m_old = m_new; m_new = m_cand; m_kv = 1; m_mode = 2; m_hi = 0;
          end
        end
        default: begin
          // released once colen stays high for D+1 consecutive samples
          if (colen) m_hi++; else m_hi = 0;
          if (m_hi == D + 1) m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      logic sel_m;
      sel_m = (m_ref >= (1 << (MB - 1)));
      chk("digit_new", int'(digit_new), m_new);
      chk("digit_old", int'(digit_old), m_old);
      chk("key_valid", int'(key_valid), int'(m_kv));
      chk("an",        int'(an),  sel_m ? 1 : 2);
      chk("seg",       int'(seg), int'(segtab[sel_m ? m_old : m_new]));
    end
  end

  // One clock: apply inputs, advance model on the edge, return at negedge
  task automatic tick(input bit rst_n, input bit he, input logic [3:0] h, input bit ce);
    reset = rst_n; hexen = he; hex = h; colen = ce;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    #1;
    if (key_valid) kv_cnt++;
  endtask

  task automatic idle_n(input int n, input bit ce);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 4'h0, ce);
  endtask

  int c0, kv_at, kv_base;

  initial begin
    reset = 1'b0; hexen = 1'b0; hex = 4'h0; colen = 1'b1;
    @(negedge clk);
    tick(1'b0, 1'b0, 4'h0, 1'b1);
    chk_on = 1'b1;
    tick(1'b0, 1'b0, 4'h0, 1'b1);
    chk("rst_an", int'(an), 2);
    chk("rst_seg", int'(seg), 7'h40);
    chk("rst_digits", int'({digit_old, digit_new}), 0);

    // Idle display scan
    kv_cnt = 0;
    idle_n(4, 1'b1);
    chk("idle_an_left", int'(an), 1);
    idle_n(4, 1'b1);
    chk("idle_an_right", int'(an), 2);
    idle_n(8, 1'b1);
    chk("idle_no_kv", kv_cnt, 0);

    // Accept 5 with exact latency
    tick(1'b1, 1'b1, 4'h5, 1'b0);
    c0 = cyc; kv_at = -1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 4'h0, 1'b0);
      if (key_valid && kv_at < 0) kv_at = cyc - c0;
    end
    chk("kv_latency", kv_at, D + 1);
    chk("kv_single", kv_cnt, 1);
    chk("accept5_new", int'(digit_new), 5);
    chk("accept5_old", int'(digit_old), 0);

    // Release then accept A
    idle_n(6, 1'b1);
    tick(1'b1, 1'b1, 4'hA, 1'b0);
    idle_n(6, 1'b0);
    chk("acceptA_new", int'(digit_new), 4'hA);
    chk("acceptA_old", int'(digit_old), 5);
    for (int i = 0; i < 8 && an != 2'b10; i++) idle_n(1, 1'b0);
    chk("segA_an", int'(an), 2);
    chk("segA", int'(seg), 7'h08);

    // Aborted press of 3
    idle_n(6, 1'b1);
    kv_base = kv_cnt;
    tick(1'b1, 1'b1, 4'h3, 1'b0);
    idle_n(2, 1'b0);
    idle_n(4, 1'b1);
    chk("abort_no_kv", kv_cnt - kv_base, 0);
    chk("abort_digits", int'({digit_old, digit_new}), 8'h5A);

    // Accept 7, bounce release, hexen while held
    kv_base = kv_cnt;
    tick(1'b1, 1'b1, 4'h7, 1'b0);
    idle_n(6, 1'b0);
    idle_n(1, 1'b1); idle_n(1, 1'b0); idle_n(1, 1'b1);
    tick(1'b1, 1'b1, 4'h9, 1'b0);
    idle_n(3, 1'b0);
    tick(1'b1, 1'b1, 4'h9, 1'b1);
    idle_n(6, 1'b1);
    idle_n(6, 1'b0);
    chk("held_single_kv", kv_cnt - kv_base, 1);
    chk("held_new7", int'(digit_new), 7);
    chk("held_old", int'(digit_old), 4'hA);

    // Reset mid press of C
    kv_base = kv_cnt;
    tick(1'b1, 1'b1, 4'hC, 1'b0);
    idle_n(2, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 1'b0);
    idle_n(8, 1'b0);
    chk("rst_abort_kv", kv_cnt - kv_base, 0);
    chk("rst_abort_digits", int'({digit_old, digit_new}), 0);

    // Randomized traffic: colen in runs, sparse hexen, rare reset
    begin
      bit ce;
      int run;
      ce = 1'b1; run = 0;
      for (int i = 0; i < 3000; i++) begin
        if (run == 0) begin
          ce  = ~ce;
          run = $urandom_range(1, 9);
        end
        run--;
        tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
             4'($urandom_range(0, 15)), ce);
      end
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
